jstk_spi_reader: RTL and testbench
==================================

Name: jstk_spi_reader

Overview:
- SPI master that polls the PmodJSTK joystick and produces the `xPosData`/`yPosData` position words consumed by the game engine.
- Runs on the board system clock and autonomously issues one 5-byte SPI transaction per poll period.
- Assembles the 10-bit X/Y positions and button bits, then updates its outputs atomically with a one-cycle valid strobe.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period (SCLK must stay below 1 MHz).
- SETUP_CYC, 1500: clk cycles from `ss_n` low to the first SCLK edge (15 us at 100 MHz).
- GAP_CYC, 1000: clk cycles of idle SCLK between bytes (10 us).
- POLL_CYC, 3333333: clk cycles from end of one transaction to start of the next (about 30 Hz).
- DEADZONE, 16: half-width of the centre snap window; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- leds  in  2  LED command bits sent to the joystick.
- miso  in  1  joystick serial data out.
- sclk  out  1  SPI clock, mode 0, idles low.
- mosi  out  1  SPI data to joystick, MSB first.
- ss_n  out  1  slave select, active low.
- xPosData  out  10  latest X position, 0..1023.
- yPosData  out  10  latest Y position, 0..1023.
- buttons  out  3  {btn2, btn1, trigger}.
- data_valid  out  1  one-cycle pulse when X/Y/buttons update.
- busy  out  1  high while `ss_n` is low.

Behaviour:
- Reset, asynchronous, active low. While `rst_n` is low:
  - `ss_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `data_valid`=0;
  - `xPosData`=512, `yPosData`=512, `buttons`=0;
  - all counters 0, FSM in IDLE.
- Reset asserted mid-transaction: `ss_n` rises immediately, the partial frame is discarded and outputs return to reset values.
- FSM states: IDLE -> SETUP -> SHIFT -> GAP -> (SHIFT | DONE) -> IDLE.
- IDLE:
  - The poll counter increments each cycle.
  - At POLL_CYC-1: sample `leds`, drive `ss_n`=0 and `busy`=1, go to SETUP.
  - The first transaction therefore starts POLL_CYC cycles after reset release.
- SETUP: wait SETUP_CYC cycles with `sclk` low, then go to SHIFT with byte index 0.
- SHIFT, per bit:
  - `mosi` is valid for the whole low phase; CLK_DIV cycles low, then CLK_DIV cycles high.
  - `miso` is sampled in the clk cycle where `sclk` goes 0->1.
  - `mosi` changes only on `sclk` 1->0 or on entry to the byte.
  - Eight bits per byte, MSB first.
  - Byte 0 `mosi` = 8'h80 | {6'b0, leds}; bytes 1-4 `mosi` = 8'h00.
- After bit 7's high phase, `sclk` returns low:
  - if byte index < 4, go to GAP;
  - otherwise go to DONE.
- GAP: GAP_CYC cycles with `sclk` low and `mosi` low, then SHIFT with byte index +1.
- DONE, single cycle:
  - `ss_n`=1, `busy`=0, poll counter cleared.
  - `xPosData` = {byte1[1:0], byte0}, `yPosData` = {byte3[1:0], byte2}, `buttons` = byte4[2:0].
  - `data_valid`=1 for this cycle only.
  - Unused high bits of bytes 1, 3 and 4 are ignored.
- Latency: `data_valid` asserts exactly SETUP_CYC + 5·16·CLK_DIV + 4·GAP_CYC + 1 cycles after `ss_n` falls.
- `leds` changes during a transaction have no effect until the next one.
- Outputs hold between `data_valid` pulses; they are never partially updated.

Optional Feature:
- Macro: JSTK_DEADZONE_EN.
- When defined, in DONE each axis value v with 512-DEADZONE <= v <= 512+DEADZONE is output as 512; other values pass unchanged.
  - Comparison is unsigned 11-bit to avoid wrap.
- When undefined: raw values are output and DEADZONE is unused.

Decomposition:
- Shared package `jstk_pkg`:
  - FSM state encodings (IDLE, SETUP, SHIFT, GAP, DONE);
  - JSTK_CENTER=10'd512;
  - JSTK_CMD_LED=8'h80;
  - JSTK_NBYTES=5.
- Sub-module `spi_byte_shifter`:
  - ports: load strobe, tx byte, `miso`, `sclk`, `mosi`, rx byte, byte-done pulse;
  - owns the CLK_DIV divider and bit counter.
  - The top owns the FSM, SETUP/GAP/poll timers and frame assembly.

Test Plan:
Bench parameters: CLK_DIV=2, SETUP_CYC=4, GAP_CYC=4, POLL_CYC=64, DEADZONE=16.
1. Reset release, slave returns F4,01,2C,03,05:
   - `ss_n` falls at cycle 64;
   - `data_valid` pulses once 181 cycles later;
   - `xPosData`=500, `yPosData`=812, `buttons`=3'b101.
2. `leds`=2'b10 at transaction start:
   - MOSI byte 0 captured by slave = 8'h82, bytes 1-4 = 8'h00;
   - `sclk` never exceeds 2-cycle half-period;
   - `sclk` stays low for 4 cycles after `ss_n` falls and for 4 cycles between bytes.
3. Two back-to-back frames, second returns 5E,01,00,00,00:
   - outputs hold 500/812 until the second `data_valid`;
   - then `xPosData`=350, `yPosData`=0, `buttons`=0;
   - 64 cycles between `ss_n` rise and the next fall.
4. Assert `rst_n`=0 during byte 2:
   - `ss_n`=1, `sclk`=0, X/Y=512, `buttons`=0 in the same cycle;
   - after release the next `ss_n` fall comes 64 cycles later.
5. X=520, Y=700 frame (08,02,BC,02,00):
   - with JSTK_DEADZONE_EN, `xPosData`=512 and `yPosData`=700;
   - without it, `xPosData`=520 and `yPosData`=700.
6. Slave returns high garbage FF,FF,FF,FF,FF: `xPosData`=1023, `yPosData`=1023, `buttons`=3'b111, no overflow.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI reader: FSM encoding, frame constants,
// and the centre-snap helper used when JSTK_DEADZONE_EN is defined.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } jstk_state_e;

  localparam logic [9:0] JSTK_CENTER  = 10'd512;
  localparam logic [7:0] JSTK_CMD_LED = 8'h80;
  localparam int         JSTK_NBYTES  = 5;

  // 11-bit compare keeps the window edges from wrapping near 0/1023.
  function automatic logic [9:0] jstk_snap(input logic [9:0] v,
                                           input int unsigned dz,
                                           input logic en);
    logic [10:0] vv, lo, hi;
    vv = {1'b0, v};
    lo = 11'(JSTK_CENTER) - 11'(dz);
    hi = 11'(JSTK_CENTER) + 11'(dz);
    return (en && (vv >= lo) && (vv <= hi)) ? JSTK_CENTER : v;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte: CLK_DIV cycles low, CLK_DIV high per bit, MSB first.
// o_done is a combinational pulse on the cycle bit 7's high phase ends.
module spi_byte_shifter #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic [7:0] o_rx,
  output logic       o_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic             r_active;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic             r_sclk;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
  assign o_done = r_active && r_sclk && w_tick && (r_bit == 3'd7);
  assign o_sclk = r_sclk;
  assign o_mosi = r_tx[7];
  assign o_rx   = r_rx;

  // Shifting the tx register with zero fill leaves mosi low once the byte ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_tx     <= i_tx;
    end else if (r_active) begin
      if (w_tick) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], i_miso};
        end else begin
          r_sclk <= 1'b0;
          r_tx   <= {r_tx[6:0], 1'b0};
          if (r_bit == 3'd7) r_active <= 1'b0;
          else               r_bit    <= r_bit + 3'd1;
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/jstk_spi_reader.sv
// PmodJSTK poller: one 5-byte SPI frame per poll period, atomic X/Y/button update.
// Optional centre dead-zone snapping is enabled by defining JSTK_DEADZONE_EN.
module jstk_spi_reader
  import jstk_pkg::*;
#(
  parameter int CLK_DIV   = 50,
  parameter int SETUP_CYC = 1500,
  parameter int GAP_CYC   = 1000,
  parameter int POLL_CYC  = 3333333,
  parameter int DEADZONE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] leds,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss_n,
  output logic [9:0] xPosData,
  output logic [9:0] yPosData,
  output logic [2:0] buttons,
  output logic       data_valid,
  output logic       busy
);

  localparam int POLL_W = $clog2(POLL_CYC + 1);
  localparam int TMR_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
`ifdef JSTK_DEADZONE_EN
  localparam logic DZ_EN = 1'b1;
`else
  localparam logic DZ_EN = 1'b0;
`endif

  jstk_state_e       r_state;
  logic [POLL_W-1:0] r_poll;
  logic [TMR_W-1:0]  r_tmr;
  logic [2:0]        r_byte;
  logic [1:0]        r_led;
  logic              r_ss_n;
  logic              r_busy;
  logic              r_dv;
  logic [9:0]        r_x, r_y;
  logic [2:0]        r_btn;
  logic [7:0]        r_xl, r_yl;
  logic [1:0]        r_xh, r_yh;
  logic [2:0]        r_bh;

  logic              w_load;
  logic [7:0]        w_tx;
  logic [7:0]        w_rx;
  logic              w_done;
  logic              w_setup_end, w_gap_end;

  assign w_setup_end = (r_state == ST_SETUP) && (r_tmr == TMR_W'(SETUP_CYC - 1));
  assign w_gap_end   = (r_state == ST_GAP)   && (r_tmr == TMR_W'(GAP_CYC - 1));
  assign w_load      = w_setup_end || w_gap_end;
  // Only the first byte of the frame carries the LED command.
  assign w_tx        = w_setup_end ? (JSTK_CMD_LED | {6'b0, r_led}) : 8'h00;

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_tx   (w_tx),
    .i_miso (miso),
    .o_sclk (sclk),
    .o_mosi (mosi),
    .o_rx   (w_rx),
    .o_done (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_poll  <= '0;
      r_tmr   <= '0;
      r_byte  <= '0;
      r_led   <= '0;
      r_ss_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_dv    <= 1'b0;
      r_x     <= JSTK_CENTER;
      r_y     <= JSTK_CENTER;
      r_btn   <= '0;
      r_xl    <= '0;
      r_yl    <= '0;
      r_xh    <= '0;
      r_yh    <= '0;
      r_bh    <= '0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_poll == POLL_W'(POLL_CYC - 1)) begin
            r_led   <= leds;
            r_ss_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_tmr   <= '0;
            r_state <= ST_SETUP;
          end else begin
            r_poll <= r_poll + POLL_W'(1);
          end
        end
        ST_SETUP: begin
          if (w_setup_end) begin
            r_tmr   <= '0;
            r_byte  <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            case (r_byte)
              3'd0:    r_xl <= w_rx;
              3'd1:    r_xh <= w_rx[1:0];
              3'd2:    r_yl <= w_rx;
              3'd3:    r_yh <= w_rx[1:0];
              default: r_bh <= w_rx[2:0];
            endcase
            r_tmr   <= '0;
            r_state <= (r_byte == 3'(JSTK_NBYTES - 1)) ? ST_DONE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_gap_end) begin
            r_tmr   <= '0;
            r_byte  <= r_byte + 3'd1;
            r_state <= ST_SHIFT;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        ST_DONE: begin
          r_ss_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_poll  <= '0;
          r_dv    <= 1'b1;
          r_x     <= jstk_snap({r_xh, r_xl}, DEADZONE, DZ_EN);
          r_y     <= jstk_snap({r_yh, r_yl}, DEADZONE, DZ_EN);
          r_btn   <= r_bh;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ss_n       = r_ss_n;
  assign busy       = r_busy;
  assign data_valid = r_dv;
  assign xPosData   = r_x;
  assign yPosData   = r_y;
  assign buttons    = r_btn;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Scoreboard bench for jstk_spi_reader with a behavioural PmodJSTK slave.
module tb_jstk_spi_reader;

  localparam int CLK_DIV = 2, SETUP_CYC = 4, GAP_CYC = 4, POLL_CYC = 64, DEADZONE = 16;
  localparam int LAT = SETUP_CYC + 5 * 16 * CLK_DIV + 4 * GAP_CYC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] leds = 2'b00;
  logic       miso;
  logic       sclk, mosi, ss_n, data_valid, busy;
  logic [9:0] xPosData, yPosData;
  logic [2:0] buttons;

  jstk_spi_reader #(
    .CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC),
    .POLL_CYC(POLL_CYC), .DEADZONE(DEADZONE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .leds(leds), .miso(miso), .sclk(sclk), .mosi(mosi),
    .ss_n(ss_n), .xPosData(xPosData), .yPosData(yPosData), .buttons(buttons),
    .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0, n_dv = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int x; int y; int b; } exp_t;
  exp_t        exp_q[$];
  logic [39:0] frm_q[$];

  // Slave: loads a frame on ss_n fall, shifts miso on sclk fall, captures mosi on rise.
  logic [39:0] cur = '0;
  logic [7:0]  s_sh = '0, m_sh = '0;
  logic [7:0]  mosi_cap [5];
  int          s_bit = 0, s_byte = 0;
  assign miso = s_sh[7];

  always @(negedge ss_n) begin
    cur    = (frm_q.size() != 0) ? frm_q.pop_front() : 40'h0;
    s_byte = 0;
    s_bit  = 0;
    s_sh   = cur[39:32];
  end
  always @(posedge sclk) if (ss_n === 1'b0) begin
    m_sh = {m_sh[6:0], mosi};
    s_bit++;
    if (s_bit == 8 && s_byte < 5) mosi_cap[s_byte] = m_sh;
  end
  always @(negedge sclk) if (ss_n === 1'b0) begin
    if (s_bit == 8) begin
      s_bit = 0;
      s_byte++;
      s_sh = (s_byte < 5) ? cur[39 - 8 * s_byte -: 8] : 8'h00;
    end else begin
      s_sh = {s_sh[6:0], 1'b0};
    end
  end

  // sclk run-length monitor over the current frame.
  int lo_q[$], hi_q[$];
  int lo_run = 0, hi_run = 0;
  bit in_fr = 0;
  always @(negedge clk) begin
    if (!rst_n || ss_n) in_fr = 0;
    else begin
      if (!in_fr) begin
        in_fr = 1; lo_q.delete(); hi_q.delete(); lo_run = 0; hi_run = 0;
      end
      if (sclk) begin
        hi_run++;
        if (lo_run != 0) begin lo_q.push_back(lo_run); lo_run = 0; end
      end else begin
        lo_run++;
        if (hi_run != 0) begin hi_q.push_back(hi_run); hi_run = 0; end
      end
    end
  end

  // Scoreboard: compare every data_valid against the next expected frame.
  always @(negedge clk) if (rst_n && data_valid) begin
    exp_t e;
    n_dv++;
    if (exp_q.size() == 0) chk("dv_unexpected", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("xPos", xPosData, e.x);
      chk("yPos", yPosData, e.y);
      chk("buttons", buttons, e.b);
    end
  end

  task automatic push_frame(input logic [39:0] f, input int x, input int y, input int b);
    exp_t e;
    e.x = x; e.y = y; e.b = b;
    frm_q.push_back(f);
    exp_q.push_back(e);
  endtask

  task automatic wait_ss(input logic lvl, input string tag, output int at);
    int n = 0;
    while (ss_n !== lvl && n < 3000) begin @(negedge clk); n++; end
    if (ss_n !== lvl) chk(tag, ss_n, lvl);
    at = cyc;
  endtask

  task automatic wait_dv(input string tag, output int at);
    int n = 0;
    while (data_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (data_valid !== 1'b1) chk(tag, data_valid, 1);
    at = cyc;
  endtask

  task automatic check_sclk();
    int n_long = 0, min_long = 1 << 30, bad_short = 0, bad_hi = 0;
    foreach (lo_q[i]) begin
      if (lo_q[i] > CLK_DIV) begin
        n_long++;
        if (lo_q[i] < min_long) min_long = lo_q[i];
      end else if (lo_q[i] != CLK_DIV) bad_short++;
    end
    foreach (hi_q[i]) if (hi_q[i] != CLK_DIV) bad_hi++;
    chk("sclk_rises", lo_q.size(), 40);
    chk("sclk_high_runs", hi_q.size(), 40);
    chk("sclk_high_len", bad_hi, 0);
    chk("sclk_low_len", bad_short, 0);
    chk("sclk_idle_spans", n_long, 5);
    chk("sclk_idle_min_ok", int'(min_long >= SETUP_CYC && min_long >= GAP_CYC), 1);
  endtask

  int t0, f1, d1, f2, d2, f3, f4, d4, f5, d5, hold_bad, n;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x4;
`ifdef JSTK_DEADZONE_EN
    x4 = 512;
`else
    x4 = 520;
`endif
    push_frame(40'hF4_01_2C_03_05, 500, 812, 5);
    push_frame(40'h5E_01_00_00_00, 350, 0, 0);
    push_frame(40'hAA_03_55_03_07, 0, 0, 0);     // aborted by reset
    push_frame(40'h08_02_BC_02_00, x4, 700, 0);
    push_frame(40'hFF_FF_FF_FF_FF, 1023, 1023, 7);
    leds = 2'b10;

    repeat (3) @(negedge clk);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_x", xPosData, 512);
    chk("rst_y", yPosData, 512);
    chk("rst_btn", buttons, 0);

    // Frame 1: latency, LED command, sclk timing; leds change mid-frame.
    rst_n = 1'b1; t0 = cyc;
    wait_ss(1'b0, "ss_fall1", f1);
    chk("poll_first", f1 - t0, POLL_CYC);
    chk("busy_in_frame", busy, 1);
    leds = 2'b01;
    wait_dv("dv1", d1);
    chk("latency1", d1 - f1, LAT);
    chk("busy_after", busy, 0);
    @(negedge clk);
    chk("dv_one_cycle", data_valid, 0);
    chk("mosi_b0", mosi_cap[0], 8'h82);
    chk("mosi_b1_4", mosi_cap[1] | mosi_cap[2] | mosi_cap[3] | mosi_cap[4], 0);
    check_sclk();

    // Frame 2: outputs hold until the next pulse; poll gap from ss_n rise.
    hold_bad = 0; n = 0;
    while (ss_n !== 1'b0 && n < 3000) begin
      if (xPosData !== 10'd500 || yPosData !== 10'd812) hold_bad++;
      @(negedge clk); n++;
    end
    f2 = cyc;
    chk("poll_gap", f2 - d1, POLL_CYC);
    n = 0;
    while (data_valid !== 1'b1 && n < 3000) begin
      if (xPosData !== 10'd500 || yPosData !== 10'd812) hold_bad++;
      @(negedge clk); n++;
    end
    d2 = cyc;
    chk("hold_outputs", hold_bad, 0);
    chk("latency2", d2 - f2, LAT);
    chk("mosi_b0_leds01", mosi_cap[0], 8'h81);
    @(negedge clk);

    // Frame 3: reset during byte 2.
    wait_ss(1'b0, "ss_fall3", f3);
    repeat (SETUP_CYC + 2 * (16 * CLK_DIV + GAP_CYC) + 10) @(negedge clk);
    chk("in_byte2", s_byte, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", ss_n, 1);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_x", xPosData, 512);
    chk("mid_rst_y", yPosData, 512);
    chk("mid_rst_btn", buttons, 0);
    chk("mid_rst_busy", busy, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; t0 = cyc;
    wait_ss(1'b0, "ss_fall4", f4);
    chk("poll_after_rst", f4 - t0, POLL_CYC);

    // Frames 4 and 5: dead-zone case and all-ones data.
    wait_dv("dv4", d4);
    chk("latency4", d4 - f4, LAT);
    @(negedge clk);
    wait_ss(1'b0, "ss_fall5", f5);
    wait_dv("dv5", d5);
    chk("latency5", d5 - f5, LAT);
    repeat (5) @(negedge clk);
    chk("dv_count", n_dv, 4);
    chk("exp_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
